// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity codes and baud divisor helper
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Rounded divisor so that the bit period error stays within half a clock.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with clear, end-of-bit and pre-end flags
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_end,
    output logic o_pre_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_bit_end = (r_cnt == LAST);
    assign o_pre_end = (r_cnt == PRE);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8E1/8O1/8x2 UART transmitter with registered outputs
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_din,
    input  logic       uart_tx_start,
    output logic       tx_done,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);

    generate
        if (CPB < 4) begin : g_bad_baud
            $error("uart_tx: CLKS_PER_BIT must be at least 4");
        end
        if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
            $error("uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [7:0] r_byte;
    logic [2:0] r_bit_idx;
    logic       r_tx;
    logic       r_done;
    logic       r_tick;

    logic w_bit_end;
    logic w_pre_end;
    logic w_parity;
    logic w_last_stop;

    // Counter is held at zero while idle so the start bit gets a full period.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_clear  (r_state == TX_IDLE),
        .o_bit_end(w_bit_end),
        .o_pre_end(w_pre_end)
    );

    assign w_parity    = (^r_byte) ^ (PARITY == PARITY_ODD);
    assign w_last_stop = (STOP_BITS == 1) || r_bit_idx[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= TX_IDLE;
            r_shift   <= '0;
            r_byte    <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b1;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    r_tx   <= 1'b1;
                    r_done <= 1'b1;
                    if (uart_tx_start) begin
                        r_shift <= uart_din;
                        r_byte  <= uart_din;
                        r_tx    <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            if (PARITY != PARITY_NONE) begin
                                r_tx    <= w_parity;
                                r_state <= TX_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= TX_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    // Tick is registered one cycle early so it covers the final stop cycle.
                    if (w_pre_end && w_last_stop) begin
                        r_tick <= 1'b1;
                    end
                    if (w_bit_end) begin
                        if (w_last_stop) begin
                            r_bit_idx <= '0;
                            r_done    <= 1'b1;
                            r_state   <= TX_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_done  <= 1'b1;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx           = r_tx;
    assign tx_done      = r_done;
    assign tx_done_tick = r_tick;

endmodule
